// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: Fibonacci sequencer for the register-file / mux / ALU / bus
// datapath. Fills r1..r(lr) with successive Fibonacci terms, lr captured
// (and clamped) on start. r0 is assumed to hold 0 and is never written.
//
// Optional feature: define FIB_OVF_EN to add the alu_carry input and the
// ovf_err output; a carry during EXEC then ends the run early.
//
// state  | meaning
// IDLE   | waiting for start
// SEED_L | left operand <- r0
// SEED_I | right operand <- immediate 1
// SEED_W | write r0 + 1 into r1
// LOAD_L | left operand <- r(k-1)
// LOAD_R | right operand <- r(k-2)
// EXEC   | write r(k-1) + r(k-2) into rk
// DONE   | one-cycle completion pulse
module fib_seq_ctrl #(
    parameter int              DATA_W   = 16,
    parameter int              NUM_REGS = 16,
    parameter int              SEL_W    = 5,
    parameter int              OP_W     = 8,
    parameter logic [OP_W-1:0] OP_ADD   = 8'b00000101,
    parameter int              IDX_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step_en,
    input  logic [IDX_W-1:0]    last_reg,
    output logic [DATA_W-1:0]   immediate,
    output logic                imm_control,
    output logic [NUM_REGS-1:0] enable,
    output logic [SEL_W-1:0]    control1,
    output logic [SEL_W-1:0]    control2,
    output logic [OP_W-1:0]     opcode,
    output logic                buff_en,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    term_idx
`ifdef FIB_OVF_EN
    ,
    input  logic                alu_carry,
    output logic                ovf_err
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED_L = 3'd1,
        SEED_I = 3'd2,
        SEED_W = 3'd3,
        LOAD_L = 3'd4,
        LOAD_R = 3'd5,
        EXEC   = 3'd6,
        DONE   = 3'd7
    } state_t;

    localparam logic [IDX_W-1:0] LR_MAX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_1  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_2  = IDX_W'(2);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] lr_q, lr_d;
    logic [IDX_W-1:0] lr_clamped;
    logic             stop_exec;

`ifdef FIB_OVF_EN
    logic ovf_q, ovf_d;
    assign stop_exec = alu_carry;
    assign ovf_err   = ovf_q;
`else
    assign stop_exec = 1'b0;
`endif

    // State, term index and captured length registers; async reset to IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            lr_q    <= IDX_1;
`ifdef FIB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lr_q    <= lr_d;
`ifdef FIB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic; nothing moves while step_en is low
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lr_d    = lr_q;
`ifdef FIB_OVF_EN
        ovf_d   = ovf_q;
`endif
        // Length 0 would leave nothing to write, so the shortest run is r1 only
        if (last_reg == '0) begin
            lr_clamped = IDX_1;
        end else if (32'(last_reg) >= NUM_REGS) begin
            lr_clamped = LR_MAX;
        end else begin
            lr_clamped = last_reg;
        end

        if (step_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SEED_L;
                        lr_d    = lr_clamped;
                        k_d     = '0;
`ifdef FIB_OVF_EN
                        ovf_d   = 1'b0;
`endif
                    end
                end
                SEED_L: state_d = SEED_I;
                SEED_I: state_d = SEED_W;
                SEED_W: begin
                    if (lr_q == IDX_1) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_L;
                        k_d     = IDX_2;
                    end
                end
                LOAD_L: state_d = LOAD_R;
                LOAD_R: state_d = EXEC;
                EXEC: begin
                    // The write for rk happens on this edge regardless of carry
                    if (stop_exec) begin
                        state_d = DONE;
`ifdef FIB_OVF_EN
                        ovf_d   = 1'b1;
`endif
                    end else if (k_q == lr_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_L;
                        k_d     = k_q + IDX_1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore output decode from the registered state and term index
    always_comb begin
        immediate   = '0;
        imm_control = 1'b0;
        enable      = '0;
        control1    = '0;
        control2    = '0;
        opcode      = '0;
        buff_en     = 1'b0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        term_idx    = '0;
        case (state_q)
            SEED_L: control1 = SEL_W'(1);
            SEED_I: begin
                immediate   = DATA_W'(1);
                imm_control = 1'b1;
            end
            SEED_W: begin
                immediate   = DATA_W'(1);
                imm_control = 1'b1;
                opcode      = OP_ADD;
                buff_en     = 1'b1;
                enable      = NUM_REGS'(1) << 1;
                term_idx    = IDX_1;
            end
            LOAD_L: begin
                control1 = SEL_W'(k_q);
                term_idx = k_q;
            end
            LOAD_R: begin
                control2 = SEL_W'(k_q - IDX_1);
                term_idx = k_q;
            end
            EXEC: begin
                opcode   = OP_ADD;
                buff_en  = 1'b1;
                enable   = NUM_REGS'(1) << k_q;
                term_idx = k_q;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: stimulus pushes expected write/done events into a
// queue; a negedge monitor pops them as the DUT presents them and compares
// cycle, enable, term index and the value a behavioural datapath puts on the bus.
module tb_fib_seq_ctrl;
    localparam int DATA_W = 16;
    localparam int NUM_REGS = 16;
    localparam int SEL_W = 5;
    localparam int OP_W = 8;
    localparam int IDX_W = 5;
    localparam logic [7:0] OP_ADD = 8'b00000101;

    logic clk = 1'b0;
    logic reset, start, step_en;
    logic [IDX_W-1:0]    last_reg;
    logic [DATA_W-1:0]   immediate;
    logic                imm_control;
    logic [NUM_REGS-1:0] enable;
    logic [SEL_W-1:0]    control1, control2;
    logic [OP_W-1:0]     opcode;
    logic                buff_en, busy, done;
    logic [IDX_W-1:0]    term_idx;
`ifdef FIB_OVF_EN
    logic alu_carry, ovf_err;
`endif

    fib_seq_ctrl #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
                   .OP_W(OP_W), .OP_ADD(OP_ADD), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .step_en(step_en),
        .last_reg(last_reg), .immediate(immediate), .imm_control(imm_control),
        .enable(enable), .control1(control1), .control2(control2),
        .opcode(opcode), .buff_en(buff_en), .busy(busy), .done(done),
        .term_idx(term_idx)
`ifdef FIB_OVF_EN
        , .alu_carry(alu_carry), .ovf_err(ovf_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] en;
        int          idx;
        int          val;
        logic        dn;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  t0 = 0;
    logic adv_q = 1'b0;
    logic [15:0] rf [16] = '{default: 16'h0};
    logic [15:0] opa = 16'h0;
    logic [15:0] opb = 16'h0;
    int fib [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Behavioural datapath: operand latches, adder, register file
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        adv_q <= step_en;
        if (control1 != '0) opa <= rf[4'(control1 - 5'd1)];
        if (imm_control) opb <= immediate;
        else if (control2 != '0) opb <= rf[4'(control2 - 5'd1)];
        if (buff_en && opcode == OP_ADD)
            for (int i = 1; i < 16; i++)
                if (enable[i]) rf[i] <= opa + opb;
    end

    // Monitor: pop an expected event whenever a write or done appears
    always @(negedge clk) begin
        if (!reset) begin
            chk("enable_onehot", int'($onehot0(enable)), 1);
            if (adv_q && (enable != '0 || done)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual en=%h done=%b required no event", enable, done);
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("event_cycle", cyc - t0, mon_ev.cyc);
                    chk("event_enable", int'(enable), int'(mon_ev.en));
                    chk("event_done", int'(done), int'(mon_ev.dn));
                    if (mon_ev.dn) begin
                        chk("done_busy", int'(busy), 1);
                    end else begin
                        chk("event_term_idx", int'(term_idx), mon_ev.idx);
                        chk("event_bus_value", int'(opa + opb), mon_ev.val);
                        chk("event_opcode", int'(opcode), int'(OP_ADD));
                        chk("event_buff_en", int'(buff_en), 1);
                    end
                end
            end
        end
    end

    // Expected events for a run of length lr; events after stall_after slip by stall_len
    task automatic push_run(input int lr, input int stall_after, input int stall_len);
        ev_t e;
        int  c;
        e = '{cyc: 3, en: 16'h0002, idx: 1, val: 1, dn: 1'b0};
        exp_q.push_back(e);
        for (int k = 2; k <= lr; k++) begin
            c = 3 * k;
            if (c > stall_after) c = c + stall_len;
            e = '{cyc: c, en: 16'(1) << k, idx: k, val: fib[k], dn: 1'b0};
            exp_q.push_back(e);
        end
        c = 3 * lr + 1;
        if (c > stall_after) c = c + stall_len;
        e = '{cyc: c, en: 16'h0000, idx: 0, val: 0, dn: 1'b1};
        exp_q.push_back(e);
    endtask

    // t0 is chosen so that the first state after the start edge is cycle 1
    task automatic start_run(input int lr_in);
        @(negedge clk);
        last_reg = IDX_W'(lr_in);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual pending=%0d required pending=0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #1;
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_idle_done"}, int'(done), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_outs"}, int'({enable, control1, control2, opcode, immediate,
                                   imm_control, buff_en, done, term_idx} != '0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        step_en = 1'b1;
        last_reg = '0;
`ifdef FIB_OVF_EN
        alu_carry = 1'b0;
`endif
        #1;
        chk_all_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // lr = 3: basic run
        push_run(3, 1000, 0);
        start_run(3);
        drain("run3");
        chk("run3_r1", int'(rf[1]), 1);
        chk("run3_r2", int'(rf[2]), 1);
        chk("run3_r3", int'(rf[3]), 2);

        // lr = 0 clamps to 1
        push_run(1, 1000, 0);
        start_run(0);
        drain("run0");

        // lr = 20 clamps to 15
        push_run(15, 1000, 0);
        start_run(20);
        drain("run20");
        chk("run20_r10", int'(rf[10]), 55);
        chk("run20_r15", int'(rf[15]), 610);

        // stall 5 cycles in LOAD_R at k = 2
        push_run(3, 5, 5);
        start_run(3);
        repeat (5) @(negedge clk);
        #1;
        chk("stall_entry_c2", int'(control2), 1);
        step_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("stall_c2", int'(control2), 1);
            chk("stall_idx", int'(term_idx), 2);
            chk("stall_busy", int'(busy), 1);
        end
        step_en = 1'b1;
        drain("stall");

        // start while busy is ignored and does not recapture lr
        push_run(3, 1000, 0);
        start_run(3);
        @(negedge clk);
        last_reg = IDX_W'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_reg = IDX_W'(9);
        drain("busy_start");

        // reset during EXEC at k = 4 aborts without done
        push_run(6, 1000, 0);
        start_run(6);
        repeat (12) @(negedge clk);
        #2;
        chk("pre_reset_exec_en", int'(enable), 16'h0010);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_reset_done", int'(done), 0);
            chk("post_reset_busy", int'(busy), 0);
        end
        push_run(4, 1000, 0);
        start_run(4);
        drain("after_reset");
        chk("after_reset_r4", int'(rf[4]), 3);

`ifdef FIB_OVF_EN
        // carry in EXEC at k = 5 ends the run with ovf_err set
        push_run(5, 1000, 0);
        start_run(15);
        repeat (15) @(negedge clk);
        alu_carry = 1'b1;
        @(negedge clk);
        alu_carry = 1'b0;
        #1;
        chk("ovf_set", int'(ovf_err), 1);
        drain("ovf");
        chk("ovf_hold", int'(ovf_err), 1);
        chk("ovf_r5", int'(rf[5]), 5);
        push_run(1, 1000, 0);
        start_run(1);
        chk("ovf_clear", int'(ovf_err), 0);
        drain("ovf_next");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
